// File: rtl/cvw_pkg.sv
// Shared configuration and encodings for the D->E immediate path.
// The config struct carries only the fields this slice uses.
package cvw;

   typedef struct packed {
      int   XLEN;
      logic A_SUPPORTED;
   } cvw_t;

   localparam cvw_t CVW_RV64 = '{XLEN: 64, A_SUPPORTED: 1'b1};
   localparam cvw_t CVW_RV32 = '{XLEN: 32, A_SUPPORTED: 1'b0};

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_S     = 3'b001;
   localparam logic [2:0] IMM_B     = 3'b010;
   localparam logic [2:0] IMM_J     = 3'b011;
   localparam logic [2:0] IMM_U     = 3'b100;
   localparam logic [2:0] IMM_RSV   = 3'b101;
   localparam logic [2:0] IMM_UIMM  = 3'b110;
   localparam logic [2:0] IMM_SHAMT = 3'b111;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } immfuse_state_t;

endpackage

// File: rtl/openhw_immdec.sv
// Combinational immediate format decoder: instruction bits [31:7] plus format
// select to an XLEN-wide immediate. Undefined selects decode to zero.
module openhw_immdec
   import cvw::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:7]     instr,
   input  logic [2:0]      immsrc,
   output logic [XLEN-1:0] imm
);

   always_comb begin
      imm = '0;
      case (immsrc)
         IMM_I:     imm = XLEN'($signed(instr[31:20]));
         IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
         IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
         IMM_U:     imm = XLEN'($signed({instr[31:12], 12'h000}));
         IMM_RSV:   imm = '0;
         IMM_UIMM:  imm = XLEN'(instr[19:15]);
         // RV32 shift amounts are 5 bits; bit 25 belongs to funct7 there
         IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/openhw_immgen_fuse.sv
// Registered D->E immediate generator with LUI rd / ADDI rd,rd,imm fusion.
//   state | meaning
//   IDLE  | no LUI held; valid D instructions pass straight to E
//   PEND  | LUI U-immediate and rd held, waiting for a matching ADDI
module openhw_immgen_fuse
   import cvw::*;
#(
   parameter cvw_t P       = CVW_RV64,
   parameter int   FUSE_EN = 1,
   parameter int   TIMEOUT = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       InstrD,
   input  logic              ValidD,
   input  logic [2:0]        ImmSrcD,
   input  logic              StallE,
   input  logic              FlushE,
   output logic [P.XLEN-1:0] ImmExtE,
   output logic              ValidE,
   output logic              FusedE,
   output logic              FuseAckD,
   output logic              StallReqD
);

   localparam int XLEN = P.XLEN;

   immfuse_state_t  state, state_n;
   logic [XLEN-1:0] imm_d, uimm_d, iimm_d;
   logic [XLEN-1:0] pend_imm, pend_imm_n;
   logic [4:0]      pend_rd, pend_rd_n;
   logic [2:0]      cnt, cnt_n, cnt_inc;
   logic [XLEN-1:0] imm_e_n;
   logic            valid_e_n, fused_e_n, e_en;
   logic            is_lui, is_match;

   openhw_immdec #(.XLEN(XLEN)) u_immdec (
      .instr  (InstrD[31:7]),
      .immsrc (ImmSrcD),
      .imm    (imm_d)
   );

   // Fusion operands come straight from the instruction, independent of ImmSrcD
   assign uimm_d  = XLEN'($signed({InstrD[31:12], 12'h000}));
   assign iimm_d  = XLEN'($signed(InstrD[31:20]));
   assign cnt_inc = cnt + 3'd1;

   assign is_lui   = ValidD && (InstrD[6:0] == OP_LUI) && (InstrD[11:7] != 5'd0)
                     && (FUSE_EN != 0);
   assign is_match = ValidD && (InstrD[6:0] == OP_IMM) && (InstrD[14:12] == 3'b000)
                     && (InstrD[11:7] == pend_rd) && (InstrD[19:15] == pend_rd);

   always_comb begin
      state_n    = state;
      pend_imm_n = pend_imm;
      pend_rd_n  = pend_rd;
      cnt_n      = cnt;
      e_en       = 1'b0;
      imm_e_n    = '0;
      valid_e_n  = 1'b0;
      fused_e_n  = 1'b0;
      FuseAckD   = 1'b0;
      StallReqD  = 1'b0;
      if (reset_n) begin
         if (FlushE) begin
            e_en    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
         end else if (!StallE) begin
            e_en = 1'b1;
            case (state)
               IDLE: begin
                  if (is_lui) begin
                     pend_imm_n = uimm_d;
                     pend_rd_n  = InstrD[11:7];
                     cnt_n      = '0;
                     state_n    = PEND;
                  end else if (ValidD) begin
                     imm_e_n   = imm_d;
                     valid_e_n = 1'b1;
                  end
               end
               PEND: begin
                  if (is_match) begin
                     imm_e_n   = pend_imm + iimm_d;
                     valid_e_n = 1'b1;
                     fused_e_n = 1'b1;
                     FuseAckD  = 1'b1;
                     state_n   = IDLE;
                  end else if (ValidD) begin
                     imm_e_n   = pend_imm;
                     valid_e_n = 1'b1;
                     StallReqD = 1'b1;
                     state_n   = IDLE;
                  end else begin
                     cnt_n = cnt_inc;
                     if (cnt_inc == 3'(TIMEOUT)) begin
                        imm_e_n   = pend_imm;
                        valid_e_n = 1'b1;
                        state_n   = IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         pend_imm <= '0;
         pend_rd  <= '0;
         ImmExtE  <= '0;
         ValidE   <= 1'b0;
         FusedE   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         pend_imm <= pend_imm_n;
         pend_rd  <= pend_rd_n;
         if (e_en) begin
            ImmExtE <= imm_e_n;
            ValidE  <= valid_e_n;
            FusedE  <= fused_e_n;
         end
      end
   end

endmodule

// File: tb/tb_openhw_immgen_fuse.sv
// Bench for openhw_immgen_fuse: RV64 and RV32 instances share stimulus and are
// compared every cycle against an arithmetic reference of the fusion rules.
module tb_openhw_immgen_fuse;
   import cvw::*;

   localparam int TIMEOUT = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] InstrD;
   logic        ValidD;
   logic [2:0]  ImmSrcD;
   logic        StallE;
   logic        FlushE;
   logic [63:0] imm64;
   logic [31:0] imm32;
   logic        v64, f64, a64, s64;
   logic        v32, f32, a32, s32;

   always #5 clk = ~clk;

   openhw_immgen_fuse #(.P(CVW_RV64), .FUSE_EN(1), .TIMEOUT(TIMEOUT)) dut64 (
      .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .ValidD(ValidD), .ImmSrcD(ImmSrcD),
      .StallE(StallE), .FlushE(FlushE), .ImmExtE(imm64), .ValidE(v64), .FusedE(f64),
      .FuseAckD(a64), .StallReqD(s64)
   );

   openhw_immgen_fuse #(.P(CVW_RV32), .FUSE_EN(1), .TIMEOUT(TIMEOUT)) dut32 (
      .clk(clk), .reset_n(reset_n), .InstrD(InstrD), .ValidD(ValidD), .ImmSrcD(ImmSrcD),
      .StallE(StallE), .FlushE(FlushE), .ImmExtE(imm32), .ValidE(v32), .FusedE(f32),
      .FuseAckD(a32), .StallReqD(s32)
   );

   int nchk  = 0;
   int npass = 0;

   // reference state: at most one pending LUI, its value, rd and idle age
   bit          m_pend = 1'b0;
   logic [63:0] m_u    = '0;
   logic [4:0]  m_rd   = '0;
   int          m_idle = 0;
   logic [63:0] m_e64  = '0;
   logic [63:0] m_e32  = '0;
   bit          m_ev   = 1'b0;
   bit          m_ef   = 1'b0;
   logic        seen_ack, seen_sreq;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic longint sx(input longint raw, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (raw >= half) ? raw - (half * 2) : raw;
   endfunction

   function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                           input int xlen);
      longint v;
      case (src)
         3'd0:    v = sx(longint'(ins[31:20]), 12);
         3'd1:    v = sx(longint'({ins[31:25], ins[11:7]}), 12);
         3'd2:    v = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
         3'd3:    v = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
         3'd4:    v = sx(longint'({ins[31:12], 12'h000}), 32);
         3'd6:    v = longint'(ins[19:15]);
         3'd7:    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
         default: v = 0;
      endcase
      return (xlen == 64) ? 64'(v) : {32'h0, 32'(v)};
   endfunction

   task automatic step(input logic rn, input logic [31:0] ins, input logic vd,
                       input logic [2:0] src, input logic st, input logic fl);
      bit          n_pend, n_ev, n_ef, x_ack, x_sreq;
      logic [63:0] n_u, n_e64, n_e32, sum;
      logic [4:0]  n_rd;
      int          n_idle;
      @(negedge clk);
      reset_n = rn; InstrD = ins; ValidD = vd; ImmSrcD = src; StallE = st; FlushE = fl;
      n_pend = m_pend; n_u = m_u; n_rd = m_rd; n_idle = m_idle;
      n_e64 = m_e64; n_e32 = m_e32; n_ev = m_ev; n_ef = m_ef;
      x_ack = 1'b0; x_sreq = 1'b0;
      if (!rn || fl) begin
         n_pend = 1'b0; n_idle = 0;
         n_e64 = '0; n_e32 = '0; n_ev = 1'b0; n_ef = 1'b0;
      end else if (!st) begin
         n_e64 = '0; n_e32 = '0; n_ev = 1'b0; n_ef = 1'b0;
         if (!m_pend) begin
            if (vd && ins[6:0] == 7'h37 && ins[11:7] != 5'd0) begin
               n_pend = 1'b1; n_rd = ins[11:7]; n_idle = 0;
               n_u = 64'(sx(longint'({ins[31:12], 12'h000}), 32));
            end else if (vd) begin
               n_e64 = ref_imm(ins, src, 64); n_e32 = ref_imm(ins, src, 32); n_ev = 1'b1;
            end
         end else if (vd && ins[6:0] == 7'h13 && ins[14:12] == 3'd0
                      && ins[11:7] == m_rd && ins[19:15] == m_rd) begin
            sum = m_u + 64'(sx(longint'(ins[31:20]), 12));
            n_e64 = sum; n_e32 = {32'h0, sum[31:0]};
            n_ev = 1'b1; n_ef = 1'b1; x_ack = 1'b1; n_pend = 1'b0;
         end else if (vd) begin
            n_e64 = m_u; n_e32 = {32'h0, m_u[31:0]}; n_ev = 1'b1;
            x_sreq = 1'b1; n_pend = 1'b0;
         end else begin
            n_idle = m_idle + 1;
            if (n_idle == TIMEOUT) begin
               n_e64 = m_u; n_e32 = {32'h0, m_u[31:0]}; n_ev = 1'b1; n_pend = 1'b0;
            end
         end
      end
      #1;
      seen_ack = a64; seen_sreq = s64;
      chk("ack64", 64'(a64), 64'(x_ack));
      chk("ack32", 64'(a32), 64'(x_ack));
      chk("sreq64", 64'(s64), 64'(x_sreq));
      chk("sreq32", 64'(s32), 64'(x_sreq));
      @(posedge clk);
      #1;
      m_pend = n_pend; m_u = n_u; m_rd = n_rd; m_idle = n_idle;
      m_e64 = n_e64; m_e32 = n_e32; m_ev = n_ev; m_ef = n_ef;
      chk("imm64", imm64, m_e64);
      chk("imm32", 64'(imm32), m_e32);
      chk("valid64", 64'(v64), 64'(m_ev));
      chk("valid32", 64'(v32), 64'(m_ev));
      chk("fused64", 64'(f64), 64'(m_ef));
      chk("fused32", 64'(f32), 64'(m_ef));
   endtask

   localparam logic [31:0] LUI5  = 32'h123452B7;  // lui  x5,0x12345
   localparam logic [31:0] ADDI5 = 32'hFFF28293;  // addi x5,x5,-1
   localparam logic [31:0] LUI5B = 32'h800002B7;  // lui  x5,0x80000
   localparam logic [31:0] LUI7  = 32'hABCDE3B7;  // lui  x7,0xABCDE
   localparam logic [31:0] NOP   = 32'h00000013;

   logic [63:0] sweep_exp [8];
   logic [31:0] rnd;
   logic [4:0]  rrd;

   initial begin
      sweep_exp[0] = 64'hFFFFFFFFFFFFFFFF; sweep_exp[1] = 64'hFFFFFFFFFFFFFFFF;
      sweep_exp[2] = 64'hFFFFFFFFFFFFFFFE; sweep_exp[3] = 64'hFFFFFFFFFFFFFFFE;
      sweep_exp[4] = 64'hFFFFFFFFFFFFF000; sweep_exp[5] = 64'h0;
      sweep_exp[6] = 64'h1F;               sweep_exp[7] = 64'h3F;
      reset_n = 1'b0; InstrD = '0; ValidD = 1'b0; ImmSrcD = '0; StallE = 1'b0; FlushE = 1'b0;

      step(0, LUI5, 1, 3'd4, 0, 0);
      step(0, NOP, 1, 3'd0, 0, 0);
      chk("reset_imm", imm64, 64'h0);

      // fused pair
      step(1, LUI5, 1, 3'd4, 0, 0);
      step(1, ADDI5, 1, 3'd0, 0, 0);
      chk("fuse_ack", 64'(seen_ack), 64'h1);
      chk("fuse_val32", 64'(imm32), 64'h12344FFF);
      chk("fuse_flag", 64'(f32), 64'h1);

      // unfused LUI drained by a NOP
      step(1, LUI5B, 1, 3'd4, 0, 0);
      step(1, NOP, 1, 3'd0, 0, 0);
      chk("drain_sreq", 64'(seen_sreq), 64'h1);
      chk("drain_val64", imm64, 64'hFFFFFFFF80000000);
      step(1, NOP, 1, 3'd0, 0, 0);
      chk("nop_after_drain", imm64, 64'h0);
      chk("nop_valid", 64'(v64), 64'h1);

      // timeout emission, exactly once
      step(1, LUI7, 1, 3'd4, 0, 0);
      step(1, '0, 0, 3'd0, 0, 0);
      chk("tmo_wait_valid", 64'(v32), 64'h0);
      step(1, '0, 0, 3'd0, 0, 0);
      chk("tmo_val32", 64'(imm32), 64'hABCDE000);
      chk("tmo_valid", 64'(v32), 64'h1);
      step(1, '0, 0, 3'd0, 0, 0);
      chk("tmo_once", 64'(v32), 64'h0);

      // flush beats a matching ADDI
      step(1, LUI5, 1, 3'd4, 0, 0);
      step(1, ADDI5, 1, 3'd0, 0, 1);
      chk("flush_ack", 64'(seen_ack), 64'h0);
      step(1, LUI7, 1, 3'd4, 0, 0);
      step(1, '0, 0, 3'd0, 0, 0);
      step(1, '0, 0, 3'd0, 0, 0);
      chk("flush_relui", 64'(imm32), 64'hABCDE000);

      // stall holds PEND, then fuses
      step(1, LUI5, 1, 3'd4, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, ADDI5, 1, 3'd0, 1, 0);
         chk("stall_ack", 64'(seen_ack), 64'h0);
      end
      step(1, ADDI5, 1, 3'd0, 0, 0);
      chk("stall_fuse", 64'(imm32), 64'h12344FFF);

      // format sweep on all-ones
      for (int s = 0; s < 8; s++) begin
         step(1, 32'hFFFFFFFF, 1, 3'(s), 0, 0);
         chk($sformatf("sweep%0d", s), imm64, sweep_exp[s]);
      end

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rnd = $urandom();
         rrd = ($urandom_range(0, 3) != 0) ? m_rd : 5'($urandom_range(0, 31));
         case ($urandom_range(0, 4))
            0, 1: step($urandom_range(0, 99) >= 2, {rnd[31:12], 5'($urandom_range(0, 7)), 7'h37},
                       $urandom_range(0, 3) != 0, 3'd4,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
            2:    step($urandom_range(0, 99) >= 2, {rnd[31:20], rrd, 3'b000, rrd, 7'h13},
                       $urandom_range(0, 3) != 0, 3'd0,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
            3:    step($urandom_range(0, 99) >= 2, {rnd[31:20], rnd[19:15], rnd[14:12], rrd, 7'h13},
                       $urandom_range(0, 3) != 0, 3'd0,
                       $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
            default: step($urandom_range(0, 99) >= 2, rnd, $urandom_range(0, 3) != 0,
                          3'($urandom_range(0, 7)),
                          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
         endcase
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
